// File: rtl/trap_ctrl_if.sv
// Core-side decode and PC-side stall/redirect handshake for trap_ctrl.
interface trap_ctrl_if;
    logic        inst_valid;
    logic [31:0] pc_cur;
    logic        ecall;
    logic        mret;
    logic        illegal_inst;
    logic        CsrWrite;
    logic [11:0] csr_addr;
    logic [2:0]  csr_fun3;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output inst_valid, pc_cur, ecall, mret, illegal_inst, CsrWrite,
               csr_addr, csr_fun3, csr_wdata,
        input  csr_rdata, flush, stall, redirect, redirect_pc
    );

    modport slave (
        input  inst_valid, pc_cur, ecall, mret, illegal_inst, CsrWrite,
               csr_addr, csr_fun3, csr_wdata,
        output csr_rdata, flush, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode CSR file and trap entry / mret sequencer for the single-cycle RV32 SCPU.
// Optional macro TRAP_VECTORED_EN enables vectored mtvec mode (interrupts to base+0x2C).
module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       INT,
    trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTER, RET} state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_INT     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   mie_q, mpie_q, meie_q;
    logic [31:2]            mtvec_q, mepc_q, epc_q;
    logic [31:0]            mcause_q, cause_q;
    logic                   redirect_q;
    logic [31:0]            redirect_pc_q;
    logic [1:0]             mtvec_mode;

    logic        meip, active, take_int, trap, do_mret, csr_we;
    logic [31:0] csr_old, csr_d, cause_d, tvec_d;
    logic        unused_bits;

`ifdef TRAP_VECTORED_EN
    logic vec_q;
    assign mtvec_mode = {1'b0, vec_q};
`else
    assign mtvec_mode = 2'b00;
`endif

    assign meip     = sync_q[SYNC_STAGES-1];
    assign active   = (state_q == IDLE) && bus.inst_valid;
    assign take_int = mie_q && meie_q && meip;
    assign trap     = active && (take_int || bus.illegal_inst || bus.ecall);
    assign do_mret  = active && bus.mret && !trap;
    // A flushed instruction never commits its CSR write, so the write re-executes after return.
    assign csr_we   = active && bus.CsrWrite && !trap && !do_mret && (bus.csr_fun3[1:0] != 2'b00);

    assign unused_bits = ^{bus.csr_fun3[2], bus.pc_cur[1:0]};

    always_comb begin
        // NOTE: every variable gets a default first so no path through the cases infers a latch.
        csr_old = 32'h0;
        csr_d   = 32'h0;
        case (bus.csr_addr)
            CSR_MSTATUS: csr_old = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            CSR_MIE:     csr_old = {20'b0, meie_q, 11'b0};
            CSR_MTVEC:   csr_old = {mtvec_q, mtvec_mode};
            CSR_MEPC:    csr_old = {mepc_q, 2'b00};
            CSR_MCAUSE:  csr_old = mcause_q;
            CSR_MIP:     csr_old = {20'b0, meip, 11'b0};
            default:     csr_old = 32'h0;
        endcase
        case (bus.csr_fun3[1:0])
            2'b01:   csr_d = bus.csr_wdata;
            2'b10:   csr_d = csr_old | bus.csr_wdata;
            2'b11:   csr_d = csr_old & ~bus.csr_wdata;
            default: csr_d = csr_old;
        endcase

        cause_d = take_int ? CAUSE_INT : (bus.illegal_inst ? CAUSE_ILLEGAL : CAUSE_ECALL);
        tvec_d  = {mtvec_q, 2'b00};
`ifdef TRAP_VECTORED_EN
        if (take_int && vec_q) tvec_d = {mtvec_q, 2'b00} + 32'h0000_002C;
`endif
    end

    assign bus.csr_rdata   = csr_old;
    assign bus.flush       = trap || do_mret;
    assign bus.stall       = trap || do_mret;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC[31:2];
            mepc_q        <= '0;
            mcause_q      <= 32'h0;
            epc_q         <= '0;
            cause_q       <= 32'h0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
`ifdef TRAP_VECTORED_EN
            vec_q         <= (RESET_MTVEC[1:0] == 2'b01);
`endif
        end else begin
            // NOTE: non-blocking throughout so every update here sees pre-edge CSR values.
            sync_q[0] <= INT;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            redirect_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (trap) begin
                        epc_q         <= bus.pc_cur[31:2];
                        cause_q       <= cause_d;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= tvec_d;
                        state_q       <= ENTER;
                    end else if (do_mret) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= {mepc_q, 2'b00};
                        state_q       <= RET;
                    end else if (csr_we) begin
                        case (bus.csr_addr)
                            CSR_MSTATUS: begin
                                mie_q  <= csr_d[3];
                                mpie_q <= csr_d[7];
                            end
                            CSR_MIE:    meie_q   <= csr_d[11];
                            CSR_MTVEC: begin
                                mtvec_q <= csr_d[31:2];
`ifdef TRAP_VECTORED_EN
                                vec_q   <= (csr_d[1:0] == 2'b01);
`endif
                            end
                            CSR_MEPC:   mepc_q   <= csr_d[31:2];
                            CSR_MCAUSE: mcause_q <= csr_d;
                            default: ;
                        endcase
                    end
                end
                ENTER: begin
                    mepc_q   <= epc_q;
                    mcause_q <= cause_q;
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                    state_q  <= IDLE;
                end
                RET: begin
                    mie_q   <= mpie_q;
                    mpie_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed trap/return scenarios plus randomized CSR traffic
// against a CSR-level reference model.
module tb_trap_ctrl;
    localparam logic [31:0] TB_MTVEC = 32'h0000_0200;
    localparam int          SYNC     = 2;
    localparam logic [31:0] C_INT    = 32'h8000_000B;
    localparam logic [31:0] C_ILL    = 32'h0000_0002;
    localparam logic [31:0] C_ECALL  = 32'h0000_000B;

    logic clk = 1'b0;
    logic rst;
    logic INT;
    int   total = 0;
    int   bad   = 0;

    trap_ctrl_if bus();

    trap_ctrl #(.RESET_MTVEC(TB_MTVEC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .INT(INT),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural CSR contents as the software sees them.
    logic        m_mie, m_mpie, m_meie, m_meip;
    logic [31:0] m_mtvec, m_mepc, m_mcause;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return 32'(m_meip) << 11;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic is_int);
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
        if (is_int && m_mtvec[1:0] == 2'b01) return base + 32'd44;
`endif
        return base;
    endfunction

    task automatic m_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0; m_meip = 1'b0;
        m_mtvec = TB_MTVEC & ~32'h3; m_mepc = 32'h0; m_mcause = 32'h0;
    endtask

    task automatic m_csr(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d);
        logic [31:0] old, nv;
        old = m_read(a);
        case (f[1:0])
            2'b01: nv = d;
            2'b10: nv = old | d;
            2'b11: nv = old & ~d;
            default: return;
        endcase
        case (a)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_meie = nv[11];
`ifdef TRAP_VECTORED_EN
            12'h305: m_mtvec = {nv[31:2], (nv[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
            12'h305: m_mtvec = nv & ~32'h3;
`endif
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            default: ;
        endcase
    endtask

    task automatic m_trap(input logic [31:0] cause, input logic [31:0] pc);
        m_mepc = pc & ~32'h3; m_mcause = cause; m_mpie = m_mie; m_mie = 1'b0;
    endtask

    task automatic m_ret();
        m_mie = m_mpie; m_mpie = 1'b1;
    endtask

    // Stimulus helpers (no comparisons inside).
    task automatic clr();
        bus.inst_valid = 1'b0; bus.ecall = 1'b0; bus.mret = 1'b0; bus.illegal_inst = 1'b0;
        bus.CsrWrite = 1'b0; bus.csr_addr = 12'h0; bus.csr_fun3 = 3'b0; bus.csr_wdata = 32'h0;
        bus.pc_cur = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] v);
        bus.csr_addr = a; #1; v = bus.csr_rdata;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d);
        clr(); bus.inst_valid = 1'b1; bus.CsrWrite = 1'b1; bus.csr_addr = a;
        bus.csr_fun3 = f; bus.csr_wdata = d; bus.pc_cur = 32'h1000;
        cycle(); m_csr(a, f, d); clr();
    endtask

    task automatic run_mret(input logic [31:0] pc);
        clr(); bus.inst_valid = 1'b1; bus.mret = 1'b1; bus.pc_cur = pc;
        cycle(); m_ret(); clr(); cycle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [11:0] addrs [5] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342};
        rst = 1'b1; INT = 1'b0; clr();
        repeat (3) cycle();
        rst = 1'b0; m_reset();
        total++; if ({bus.flush, bus.stall, bus.redirect} !== 3'b000) begin bad++;
            $display("FAIL reset_ctl: got %b want 000", {bus.flush, bus.stall, bus.redirect}); end
        total++; if (bus.redirect_pc !== 32'h0) begin bad++;
            $display("FAIL reset_rpc: got %h want 00000000", bus.redirect_pc); end
        foreach (addrs[i]) begin
            peek(addrs[i], v);
            total++; if (v !== m_read(addrs[i])) begin bad++;
                $display("FAIL reset_csr_%h: got %h want %h", addrs[i], v, m_read(addrs[i])); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        logic [11:0] addrs [3] = '{12'h341, 12'h342, 12'h300};
        csr_op(12'h305, 3'b001, 32'h0000_0100);
        peek(12'h305, v);
        total++; if (v !== m_read(12'h305)) begin bad++;
            $display("FAIL ill_mtvec: got %h want %h", v, m_read(12'h305)); end
        clr(); bus.inst_valid = 1'b1; bus.illegal_inst = 1'b1; bus.pc_cur = 32'h40; #1;
        total++; if ({bus.flush, bus.stall, bus.redirect} !== 3'b110) begin bad++;
            $display("FAIL ill_detect: got %b want 110", {bus.flush, bus.stall, bus.redirect}); end
        cycle();
        total++; if ({bus.flush, bus.stall, bus.redirect} !== 3'b001 || bus.redirect_pc !== m_target(1'b0)) begin bad++;
            $display("FAIL ill_redirect: got %b/%h want 001/%h", {bus.flush, bus.stall, bus.redirect},
                     bus.redirect_pc, m_target(1'b0)); end
        m_trap(C_ILL, 32'h40);
        clr(); cycle();
        total++; if (bus.redirect !== 1'b0) begin bad++;
            $display("FAIL ill_redirect_len: got %b want 0", bus.redirect); end
        foreach (addrs[i]) begin
            peek(addrs[i], v);
            total++; if (v !== m_read(addrs[i])) begin bad++;
                $display("FAIL ill_csr_%h: got %h want %h", addrs[i], v, m_read(addrs[i])); end
        end
    endtask

    task automatic test_ecall_mret();
        logic [31:0] v, exp;
        csr_op(12'h300, 3'b010, 32'h0000_0008);
        clr(); bus.inst_valid = 1'b1; bus.ecall = 1'b1; bus.pc_cur = 32'h80; #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL ecall_flush: got %b want 1", bus.flush); end
        cycle();
        total++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== m_target(1'b0)) begin bad++;
            $display("FAIL ecall_redirect: got %b/%h want 1/%h", bus.redirect, bus.redirect_pc, m_target(1'b0)); end
        m_trap(C_ECALL, 32'h80);
        clr(); cycle();
        peek(12'h342, v);
        total++; if (v !== m_read(12'h342)) begin bad++; $display("FAIL ecall_mcause: got %h want %h", v, m_read(12'h342)); end
        peek(12'h300, v);
        total++; if (v !== m_read(12'h300)) begin bad++; $display("FAIL ecall_mstatus: got %h want %h", v, m_read(12'h300)); end
        clr(); bus.inst_valid = 1'b1; bus.mret = 1'b1; bus.pc_cur = 32'h200; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL mret_stall: got %b want 1", bus.stall); end
        exp = m_mepc;
        cycle();
        total++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== exp) begin bad++;
            $display("FAIL mret_redirect: got %b/%h want 1/%h", bus.redirect, bus.redirect_pc, exp); end
        m_ret();
        clr(); cycle();
        peek(12'h300, v);
        total++; if (v !== m_read(12'h300)) begin bad++; $display("FAIL mret_mstatus: got %h want %h", v, m_read(12'h300)); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v, pc;
        csr_op(12'h304, 3'b001, 32'h0000_0800);
        clr(); INT = 1'b1; bus.inst_valid = 1'b1;
        for (int k = 0; k <= SYNC; k++) begin
            pc = 32'h300 + 32'(4 * k);
            bus.pc_cur = pc; m_meip = (k >= SYNC);
            peek(12'h344, v);
            total++; if (v !== m_read(12'h344)) begin bad++; $display("FAIL int_mip_%0d: got %h want %h", k, v, m_read(12'h344)); end
            total++; if (bus.flush !== (k >= SYNC)) begin bad++; $display("FAIL int_latency_%0d: got %b want %b", k, bus.flush, k >= SYNC); end
            if (k < SYNC) cycle();
        end
        cycle();
        total++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== m_target(1'b1)) begin bad++;
            $display("FAIL int_redirect: got %b/%h want 1/%h", bus.redirect, bus.redirect_pc, m_target(1'b1)); end
        m_trap(C_INT, pc);
        cycle();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL int_nested: got %b want 0", bus.flush); end
        peek(12'h341, v);
        total++; if (v !== m_read(12'h341)) begin bad++; $display("FAIL int_mepc: got %h want %h", v, m_read(12'h341)); end
        peek(12'h342, v);
        total++; if (v !== m_read(12'h342)) begin bad++; $display("FAIL int_mcause: got %h want %h", v, m_read(12'h342)); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        run_mret(32'h500);
        clr(); bus.inst_valid = 1'b1; bus.CsrWrite = 1'b1; bus.csr_addr = 12'h304;
        bus.csr_fun3 = 3'b011; bus.csr_wdata = 32'h800; bus.pc_cur = 32'h600; #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL coll_csr_flush: got %b want 1", bus.flush); end
        cycle();
        total++; if (bus.redirect_pc !== m_target(1'b1)) begin bad++;
            $display("FAIL coll_csr_target: got %h want %h", bus.redirect_pc, m_target(1'b1)); end
        m_trap(C_INT, 32'h600);
        clr(); cycle();
        peek(12'h304, v);
        total++; if (v !== m_read(12'h304)) begin bad++; $display("FAIL coll_mie_kept: got %h want %h", v, m_read(12'h304)); end
        peek(12'h341, v);
        total++; if (v !== m_read(12'h341)) begin bad++; $display("FAIL coll_csr_mepc: got %h want %h", v, m_read(12'h341)); end

        run_mret(32'h604);
        clr(); bus.inst_valid = 1'b1; bus.mret = 1'b1; bus.pc_cur = 32'h608; #1;
        cycle();
        total++; if (bus.redirect_pc !== m_target(1'b1)) begin bad++;
            $display("FAIL coll_mret_target: got %h want %h", bus.redirect_pc, m_target(1'b1)); end
        m_trap(C_INT, 32'h608);
        clr(); cycle();
        peek(12'h341, v);
        total++; if (v !== m_read(12'h341)) begin bad++; $display("FAIL coll_mret_mepc: got %h want %h", v, m_read(12'h341)); end
        peek(12'h342, v);
        total++; if (v !== m_read(12'h342)) begin bad++; $display("FAIL coll_mret_mcause: got %h want %h", v, m_read(12'h342)); end

        run_mret(32'h60C);
        clr(); bus.inst_valid = 1'b1; bus.CsrWrite = 1'b1; bus.csr_addr = 12'h300;
        bus.csr_fun3 = 3'b011; bus.csr_wdata = 32'h8; bus.pc_cur = 32'h610;
        cycle(); m_trap(C_INT, 32'h610);
        clr(); cycle();
        peek(12'h300, v);
        total++; if (v !== m_read(12'h300)) begin bad++; $display("FAIL coll_mstatus: got %h want %h", v, m_read(12'h300)); end

        INT = 1'b0;
        repeat (SYNC) cycle();
        m_meip = 1'b0;
        peek(12'h344, v);
        total++; if (v !== m_read(12'h344)) begin bad++; $display("FAIL int_drop_mip: got %h want %h", v, m_read(12'h344)); end
        run_mret(32'h614);
    endtask

    task automatic test_int_glitch();
        clr(); bus.inst_valid = 1'b1; bus.pc_cur = 32'h700;
        INT = 1'b1; #2; INT = 1'b0;
        for (int k = 0; k < SYNC + 2; k++) begin
            total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL glitch_%0d: got %b want 0", k, bus.flush); end
            cycle();
        end
        clr();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            clr(); bus.inst_valid = 1'b1; bus.pc_cur = 32'h900;
            if (k == 0) bus.ecall = 1'b1; else bus.mret = 1'b1;
            cycle();
            total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL rstmid_pre_%0d: got %b want 1", k, bus.redirect); end
            rst = 1'b1; cycle(); rst = 1'b0; m_reset(); clr();
            total++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin bad++;
                $display("FAIL rstmid_redirect_%0d: got %b/%h want 0/00000000", k, bus.redirect, bus.redirect_pc); end
            peek(12'h300, v);
            total++; if (v !== m_read(12'h300)) begin bad++; $display("FAIL rstmid_mstatus_%0d: got %h want %h", k, v, m_read(12'h300)); end
            peek(12'h341, v);
            total++; if (v !== m_read(12'h341)) begin bad++; $display("FAIL rstmid_mepc_%0d: got %h want %h", k, v, m_read(12'h341)); end
        end
    endtask

    task automatic test_vectored();
        logic [31:0] v;
        csr_op(12'h305, 3'b001, 32'h0000_0102);
        peek(12'h305, v);
        total++; if (v !== m_read(12'h305)) begin bad++; $display("FAIL vec_mode2: got %h want %h", v, m_read(12'h305)); end
        csr_op(12'h305, 3'b001, 32'h0000_0101);
        peek(12'h305, v);
        total++; if (v !== m_read(12'h305)) begin bad++; $display("FAIL vec_mode1: got %h want %h", v, m_read(12'h305)); end
        csr_op(12'h300, 3'b001, 32'h8);
        csr_op(12'h304, 3'b001, 32'h800);
        INT = 1'b1; clr();
        repeat (SYNC) cycle();
        m_meip = 1'b1;
        bus.inst_valid = 1'b1; bus.pc_cur = 32'hA00;
        cycle();
        total++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== m_target(1'b1)) begin bad++;
            $display("FAIL vec_int_target: got %b/%h want 1/%h", bus.redirect, bus.redirect_pc, m_target(1'b1)); end
        m_trap(C_INT, 32'hA00);
        INT = 1'b0; clr(); cycle();
        bus.inst_valid = 1'b1; bus.ecall = 1'b1; bus.pc_cur = 32'hA04;
        cycle();
        total++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== m_target(1'b0)) begin bad++;
            $display("FAIL vec_exc_target: got %b/%h want 1/%h", bus.redirect, bus.redirect_pc, m_target(1'b0)); end
        m_trap(C_ECALL, 32'hA04);
        clr(); repeat (SYNC + 1) cycle();
        m_meip = 1'b0;
    endtask

    task automatic test_random();
        int          kind;
        logic        iv, exp_fl;
        logic [11:0] a;
        logic [31:0] tgt, exp_rd;
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            iv   = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 6))
                0: a = 12'h300;
                1: a = 12'h304;
                2: a = 12'h305;
                3: a = 12'h341;
                4: a = 12'h342;
                5: a = 12'h344;
                default: a = 12'($urandom);
            endcase
            clr();
            bus.inst_valid = iv; bus.pc_cur = $urandom; bus.csr_addr = a;
            bus.csr_fun3 = 3'($urandom); bus.csr_wdata = $urandom;
            bus.CsrWrite = (kind != 2) && ($urandom_range(0, 1) == 1);
            bus.ecall = (kind == 0); bus.illegal_inst = (kind == 1); bus.mret = (kind == 2);
            #1;
            exp_rd = m_read(a);
            total++; if (bus.csr_rdata !== exp_rd) begin bad++;
                $display("FAIL rnd_rdata_%0d: addr %h got %h want %h", n, a, bus.csr_rdata, exp_rd); end
            exp_fl = iv && (kind <= 2);
            total++; if (bus.flush !== exp_fl) begin bad++;
                $display("FAIL rnd_flush_%0d: got %b want %b", n, bus.flush, exp_fl); end
            if (exp_fl) begin
                tgt = (kind == 2) ? m_mepc : m_target(1'b0);
                cycle();
                total++; if (bus.redirect !== 1'b1 || bus.stall !== 1'b0 || bus.redirect_pc !== tgt) begin bad++;
                    $display("FAIL rnd_redirect_%0d: got %b%b/%h want 10/%h", n, bus.redirect, bus.stall, bus.redirect_pc, tgt); end
                if (kind == 2) m_ret();
                else m_trap((kind == 1) ? C_ILL : C_ECALL, bus.pc_cur);
                clr(); cycle();
            end else begin
                if (iv && bus.CsrWrite) m_csr(a, bus.csr_fun3, bus.csr_wdata);
                cycle();
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; INT = 1'b0; clr();
        test_reset();
        test_illegal();
        test_ecall_mret();
        test_interrupt();
        test_collision();
        test_int_glitch();
        test_reset_mid();
        test_vectored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap and CSR controller for the single-cycle RV32 SCPU. It consumes the control unit's CsrWrite/ecall/mret/illegal_inst/INT decode. It owns the M-mode CSRs and sequences trap entry and mret return over a 2-cycle stall/redirect handshake with the PC logic. It sits beside the register file and feeds the MemtoReg CSR path (csr_rdata).

Parameters:
RESET_MTVEC, 32'h0000_0000, reset value of mtvec
SYNC_STAGES, 2, flip-flop stages on INT before mip.MEIP (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
inst_valid  in  1  instruction at pc_cur commits this cycle
pc_cur  in  32  PC of current instruction
INT  in  1  external interrupt level, asynchronous
ecall  in  1  decoded ECALL
mret  in  1  decoded MRET
illegal_inst  in  1  decoded illegal opcode
CsrWrite  in  1  CSR instruction with write intent
csr_addr  in  12  inst[31:20]
csr_fun3  in  3  Fun3 of CSR instruction
csr_wdata  in  32  rs1 value or zero-extended zimm, pre-muxed
csr_rdata  out  32  old CSR value, combinational from csr_addr
flush  out  1  suppress RegWrite/MemRW of current instruction
stall  out  1  hold PC
redirect  out  1  load redirect_pc into PC next edge
redirect_pc  out  32  trap or return target

Behaviour:
- Reset, synchronous, all set together: state=IDLE; mstatus=32'h0000_1800 (MPP=11, MIE=0, MPIE=0); mie=0; mtvec=RESET_MTVEC; mepc=0; mcause=0; sync chain=0; flush=stall=redirect=0; redirect_pc=0.
- CSRs:
  - 0x300 mstatus: MIE bit3, MPIE bit7 writable; MPP reads 11; other bits read 0.
  - 0x304 mie: MEIE bit11 only.
  - 0x305 mtvec: bits[1:0] read 0 unless TRAP_VECTORED_EN.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: full 32 bits.
  - 0x344 mip: MEIP bit11 = last sync stage; read-only.
  - Unlisted addresses read 0; writes ignored.
- CSR ops, fun3[1:0]: 01 RW new=wdata; 10 RS new=old|wdata; 11 RC new=old&~wdata. Write commits at the clock edge when state==IDLE & inst_valid & CsrWrite & no trap taken this cycle.
- take_int = mstatus.MIE & mie.MEIE & mip.MEIP.
- Priority in IDLE with inst_valid: take_int > illegal_inst > ecall > mret.
- FSM IDLE/ENTER/RET:
  - IDLE, trap (int/illegal/ecall): flush=1, stall=1. Latch epc=pc_cur, cause: 32'h8000_000B int, 32'h0000_0002 illegal, 32'h0000_000B ecall. Go ENTER.
  - IDLE, mret: flush=1, stall=1, go RET.
  - ENTER (1 cycle): mepc<=epc; mcause<=cause; MPIE<=MIE; MIE<=0; redirect=1; redirect_pc=mtvec base ({mtvec[31:2],2'b00}). Go IDLE.
  - RET (1 cycle): MIE<=MPIE; MPIE<=1; redirect=1; redirect_pc=mepc. Go IDLE.
  - inst_valid and all decode inputs ignored in ENTER/RET.
- Latencies:
  - INT rise to MEIP visible: SYNC_STAGES edges.
  - Trap detect to redirect asserted: 1 cycle.
  - Redirect asserted for exactly 1 cycle; stall deasserted in that cycle.
- Boundary conditions:
  - Interrupt together with CSR write to mstatus/mie: trap wins; write dropped; mepc=that pc, so the instruction re-executes after mret.
  - mret with pending enabled interrupt: interrupt taken; mepc=pc of the mret.
  - INT deasserted before sync: no trap.
  - MIE=0 after entry blocks nested interrupts.
  - rst in ENTER/RET: back to IDLE, no redirect, CSRs at reset values.
  - csr_rdata reflects the pre-edge value throughout.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: mtvec[1:0] writable (values 00/01; 1x reads 00). Mode 01 sends interrupts to base+0x2C (base+4*11). Exceptions always go to base.
- Undefined: mtvec[1:0] hardwired 0; all traps go to base.

Test Plan:
- Reset, read 0x300/0x305 -> csr_rdata 32'h0000_1800 / RESET_MTVEC; flush/stall/redirect 0.
- CSRRW 0x305 wdata=32'h0000_0100, then illegal_inst at pc=0x40 -> next cycle redirect=1, redirect_pc=0x100; then mepc=0x40, mcause=2, MIE=0.
- ecall at pc=0x80 with MIE=1, then mret -> mcause=0xB, MPIE=1 after entry; mret redirect_pc=0x80, MIE restored to 1, MPIE=1.
- MIE=1, MEIE=1, INT=1 -> trap after SYNC_STAGES cycles, mcause=32'h8000_000B, mepc=pc_cur of that cycle; with MIE=0 no trap occurs.
- Interrupt pending same cycle as CSRRS mstatus and as mret -> trap taken, CSR unchanged by the write, mepc=that pc.
- TRAP_VECTORED_EN, mtvec=0x101, interrupt -> redirect_pc=0x12C; ecall -> 0x100; without macro mtvec reads 0x100.
